// File: rtl/pe_xi_4.sv
// Motion-estimation SAD processing element: two interleaved current pixels,
// one selectable reference pixel, and a registered |cur-ref| style result.
module pe_xi_4 #(
   parameter int PIXEL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIXEL-1:0] in_curr1,
   input  logic [PIXEL-1:0] in_curr2,
   input  logic             in_curr_enable,
   input  logic             CB_select,
   input  logic [1:0]       abs_Control,
   input  logic [PIXEL-1:0] up_ref_adajecent_1,
   input  logic [PIXEL-1:0] up_ref_adajecent_8,
   input  logic [PIXEL-1:0] down_ref_adajecent_1,
   input  logic [PIXEL-1:0] down_ref_adajecent_8,
   input  logic             change_ref,
   input  logic [1:0]       ref_input_Control,
   output logic [PIXEL-1:0] abs_out,
   output logic [PIXEL-1:0] next_pix1,
   output logic [PIXEL-1:0] next_pix2,
   output logic [PIXEL-1:0] ref_pix
);

   logic [PIXEL-1:0] r_curr1, r_curr2, r_ref, r_abs;
   logic [PIXEL-1:0] w_cur, w_src, w_diff, w_abs_nxt;
   logic [PIXEL:0]   w_sub;

   always_comb begin
      w_src = up_ref_adajecent_1;
      case (ref_input_Control)
         2'b00:   w_src = up_ref_adajecent_1;
         2'b01:   w_src = up_ref_adajecent_8;
         2'b10:   w_src = down_ref_adajecent_1;
         default: w_src = down_ref_adajecent_8;
      endcase
   end

   // Difference is formed from the registered pixels, never the raw inputs.
   assign w_cur  = CB_select ? r_curr2 : r_curr1;
   assign w_sub  = {1'b0, w_cur} - {1'b0, r_ref};
   assign w_diff = w_sub[PIXEL] ? (r_ref - w_cur) : w_sub[PIXEL-1:0];

   always_comb begin
      w_abs_nxt = '0;
      case (abs_Control)
         2'b00:   w_abs_nxt = w_diff;
         2'b01:   w_abs_nxt = w_diff >> 1;
         2'b10:   w_abs_nxt = w_cur;
         default: w_abs_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_curr1 <= '0;
         r_curr2 <= '0;
         r_ref   <= '0;
         r_abs   <= '0;
      end else begin
         if (in_curr_enable) begin
            r_curr1 <= in_curr1;
            r_curr2 <= in_curr2;
         end
         if (change_ref) r_ref <= w_src;
         r_abs <= w_abs_nxt;
      end
   end

   assign abs_out   = r_abs;
   assign next_pix1 = r_curr1;
   assign next_pix2 = r_curr2;
   assign ref_pix   = r_ref;

endmodule

// File: tb/tb_pe_xi_4.sv
// Scoreboard bench for pe_xi_4: directed steps push hand-computed expected
// outputs; a monitor pops one entry after each rising edge and compares.
module tb_pe_xi_4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_curr1 = '0, in_curr2 = '0;
   logic       in_curr_enable = 1'b0, CB_select = 1'b0, change_ref = 1'b0;
   logic [1:0] abs_Control = '0, ref_input_Control = '0;
   logic [7:0] up1 = '0, up8 = '0, dn1 = '0, dn8 = '0;
   logic [7:0] abs_out, next_pix1, next_pix2, ref_pix;

   typedef struct {
      string      nm;
      logic [7:0] ab, p1, p2, rf;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   pe_xi_4 #(.PIXEL(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_curr1(in_curr1), .in_curr2(in_curr2),
      .in_curr_enable(in_curr_enable), .CB_select(CB_select),
      .abs_Control(abs_Control),
      .up_ref_adajecent_1(up1), .up_ref_adajecent_8(up8),
      .down_ref_adajecent_1(dn1), .down_ref_adajecent_8(dn8),
      .change_ref(change_ref), .ref_input_Control(ref_input_Control),
      .abs_out(abs_out), .next_pix1(next_pix1), .next_pix2(next_pix2),
      .ref_pix(ref_pix)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] ab, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] rf);
      chk({nm, ".abs_out"},   abs_out,   ab);
      chk({nm, ".next_pix1"}, next_pix1, p1);
      chk({nm, ".next_pix2"}, next_pix2, p2);
      chk({nm, ".ref_pix"},   ref_pix,   rf);
   endtask

   task automatic push(input string nm, input logic [7:0] ab, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] rf);
      exp_t e;
      e.nm = nm; e.ab = ab; e.p1 = p1; e.p2 = p2; e.rf = rf;
      q.push_back(e);
   endtask

   // Monitor: outputs are present every cycle, so each edge retires one entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk_all(e.nm, e.ab, e.p1, e.p2, e.rf);
         end
      end
   end

   initial begin
      // Reset held with random inputs and enables active.
      in_curr1 = 8'($urandom); in_curr2 = 8'($urandom);
      up1 = 8'($urandom); up8 = 8'($urandom); dn1 = 8'($urandom); dn8 = 8'($urandom);
      in_curr_enable = 1'b1; change_ref = 1'b1; abs_Control = 2'b10;
      ref_input_Control = 2'($urandom); CB_select = 1'($urandom);
      #3;
      chk_all("reset_early", 8'd0, 8'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
      chk_all("reset_held", 8'd0, 8'd0, 8'd0, 8'd0);

      @(negedge clk);
      rst_n = 1'b1; in_curr_enable = 0; change_ref = 0; abs_Control = 2'b00;
      push("idle", 0, 0, 0, 0);

      @(negedge clk);
      in_curr1 = 15; in_curr2 = 7; in_curr_enable = 1; CB_select = 1;
      change_ref = 1; ref_input_Control = 2'b00;
      up1 = 1; up8 = 2; dn1 = 3; dn8 = 4; abs_Control = 2'b00;
      push("load", 0, 15, 7, 1);
      @(negedge clk); in_curr_enable = 0; change_ref = 0;
      push("sad", 6, 15, 7, 1);
      @(negedge clk); abs_Control = 2'b01;
      push("halve", 3, 15, 7, 1);

      @(negedge clk); change_ref = 1; ref_input_Control = 2'b01;
      push("ref_up8_load", 3, 15, 7, 2);
      @(negedge clk); change_ref = 0;
      push("ref_up8_abs", 2, 15, 7, 2);
      @(negedge clk); change_ref = 1; ref_input_Control = 2'b10;
      push("ref_dn1_load", 2, 15, 7, 3);
      @(negedge clk); change_ref = 0;
      push("ref_dn1_abs", 2, 15, 7, 3);
      @(negedge clk); change_ref = 1; ref_input_Control = 2'b11;
      push("ref_dn8_load", 2, 15, 7, 4);
      @(negedge clk); change_ref = 0;
      push("ref_dn8_abs", 1, 15, 7, 4);

      @(negedge clk); CB_select = 0; abs_Control = 2'b00;
      push("blk1", 11, 15, 7, 4);
      @(negedge clk); in_curr1 = 200; in_curr2 = 100; ref_input_Control = 2'b00;
      up1 = 99;
      push("hold", 11, 15, 7, 4);

      // Simultaneous load: abs_out still reflects pre-edge registers.
      @(negedge clk); in_curr1 = 0; in_curr2 = 9; in_curr_enable = 1;
      change_ref = 1; up1 = 255;
      push("dual_load", 11, 0, 9, 255);
      @(negedge clk); in_curr_enable = 0; change_ref = 0;
      push("max_diff", 255, 0, 9, 255);
      @(negedge clk); abs_Control = 2'b01;
      push("max_half", 127, 0, 9, 255);
      @(negedge clk); CB_select = 1; abs_Control = 2'b10;
      push("mode_cur", 9, 0, 9, 255);
      @(negedge clk); abs_Control = 2'b11;
      push("mode_zero", 0, 0, 9, 255);
      @(negedge clk); abs_Control = 2'b00;
      push("neg_diff", 246, 0, 9, 255);

      // Let the monitor retire the last entry, with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end

      // Asynchronous reset mid-cycle, away from any edge.
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 8'd0, 8'd0, 8'd0, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
